// File: rtl/uart_rx_system_if.sv
// Bundle of the UART receiver's serial input, divisor and received-byte outputs.
//
// Handshake: byte_ready is a one-cycle valid with no ready/backpressure. The
// consumer must take data_out in the byte_ready cycle or any later cycle, since
// data_out holds until the next good frame replaces it. state_dbg mirrors the
// receive FSM state (0=IDLE, 1=START, 2=DATA, 3=STOP) for observation only.
`timescale 1ns/1ps
interface uart_rx_system_if #(
  parameter int DVSR_WIDTH = 11
);
  logic                  serial_in;
  logic [DVSR_WIDTH-1:0] dvsr;
  logic [7:0]            data_out;
  logic                  byte_ready;
  logic [1:0]            state_dbg;

  modport master (
    output serial_in,
    output dvsr,
    input  data_out,
    input  byte_ready,
    input  state_dbg
  );

  modport slave (
    input  serial_in,
    input  dvsr,
    output data_out,
    output byte_ready,
    output state_dbg
  );
endinterface

// File: rtl/uart_rx_system.sv
// UART 8N1 receiver: programmable sample-tick generator, two-flop input
// synchroniser and a 16x oversampling receive FSM that centres each sample
// on the middle of its bit.
`timescale 1ns/1ps
module uart_rx_system #(
  parameter int DVSR_WIDTH = 11,
  parameter int OVERSAMPLE = 16
) (
  input logic             clk,
  input logic             rst,
  uart_rx_system_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Sample index where the start bit is re-checked (its midpoint) and the
  // last sample index of a whole bit.
  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

  // Synchroniser
  logic sync1;
  logic rx_s;

  // Tick generator
  logic [DVSR_WIDTH-1:0] tick_cnt;
  logic [DVSR_WIDTH-1:0] tick_limit;
  logic                  tick;

  // Receive FSM
  state_t     state, state_next;
  logic [3:0] s, s_next;
  logic [2:0] n, n_next;
  logic [7:0] shreg, shreg_next;
  logic [7:0] data_q, data_next;
  logic       ready_q, ready_next;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.serial_in;
      rx_s  <= sync1;
    end
  end

  // The terminal count is captured only at a wrap, so a divisor change never
  // strands the counter above a smaller new limit. A zero divisor acts as one.
  assign tick = (tick_cnt == tick_limit);

  // Free-running tick counter; reloads its limit from dvsr at every wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      tick_limit <= '0;
    end else if (tick) begin
      tick_cnt   <= '0;
      tick_limit <= (bus.dvsr == '0) ? '0 : (bus.dvsr - DVSR_WIDTH'(1));
    end else begin
      tick_cnt <= tick_cnt + DVSR_WIDTH'(1);
    end
  end

  // Receive FSM state, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      shreg   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      s       <= s_next;
      n       <= n_next;
      shreg   <= shreg_next;
      data_q  <= data_next;
      ready_q <= ready_next;
    end
  end

  // Next-state logic: start detection, mid-bit sampling and stop-bit check.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shreg_next = shreg;
    data_next  = data_q;
    ready_next = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            shreg_next = {rx_s, shreg[7:1]};
            s_next     = '0;
            if (n == 3'd7) begin
              state_next = STOP;
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_LAST) begin
            state_next = IDLE;
            s_next     = '0;
            // A low stop sample is a framing error: the byte is dropped.
            if (rx_s) begin
              data_next  = shreg;
              ready_next = 1'b1;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.byte_ready = ready_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_uart_rx_system.sv
// Bench for uart_rx_system: a table of frames with expected outcomes, hand
// sequences for glitch / break / async reset, and randomized frames checked
// against a byte-queue reference model.
`timescale 1ns/1ps
module tb_uart_rx_system;

  localparam int DW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_system_if #(.DVSR_WIDTH(DW)) bus ();

  uart_rx_system #(.DVSR_WIDTH(DW), .OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every byte_ready cycle must match the oldest expected byte; a pulse with
  // nothing expected (or a pulse lasting two cycles) is a failure.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.byte_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: byte_ready=1 data_out=0x%0h with no frame pending at %0t",
                 bus.data_out, $time);
      end else begin
        check("rx_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d byte(s) still pending expected 0 after %0d clocks",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int clks);
    repeat (clks) @(posedge clk);
  endtask

  task automatic drive_bit(input logic v, input int clks);
    bus.serial_in = v;
    repeat (clks) @(posedge clk);
  endtask

  task automatic set_dvsr(input int v);
    if (bus.dvsr != DW'(v)) begin
      bus.dvsr = DW'(v);
      idle(64);  // let the tick counter wrap and pick up the new divisor
    end
  endtask

  // stop_ok=0 holds the stop bit low for 10 of its 16 ticks so the midpoint
  // sample reads 0, then returns the line high for the rest of the bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int dv,
                            input int stop_ticks);
    int bp = 16 * dv;
    drive_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bp);
    if (stop_ok) begin
      drive_bit(1'b1, stop_ticks * dv);
    end else begin
      drive_bit(1'b0, 10 * dv);
      drive_bit(1'b1, 6 * dv);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         dvsr;
    logic [7:0] data;
    bit         stop_ok;
    int         stop_ticks;
    int         gap_bits;
    bit         exp_pulse;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2,  8'hA5, 1'b1, 16, 2, 1'b1, 8'hA5};  // basic receive
    vecs[1] = '{1,  8'h00, 1'b1, 16, 0, 1'b1, 8'h00};  // boundary, back-to-back
    vecs[2] = '{1,  8'hFF, 1'b1, 16, 2, 1'b1, 8'hFF};
    vecs[3] = '{2,  8'h5A, 1'b0, 16, 2, 1'b0, 8'hFF};  // framing error keeps 0xFF
    vecs[4] = '{2,  8'h81, 1'b1, 16, 2, 1'b1, 8'h81};
    vecs[5] = '{5,  8'hC3, 1'b1, 16, 2, 1'b1, 8'hC3};  // divisor sweep
    vecs[6] = '{27, 8'hC3, 1'b1, 16, 1, 1'b1, 8'hC3};
    vecs[7] = '{3,  8'h96, 1'b1, 10, 0, 1'b1, 8'h96};  // short stop, next start follows
    vecs[8] = '{3,  8'h69, 1'b1, 16, 2, 1'b1, 8'h69};

    // ---- reset state ----
    rst           = 1'b1;
    bus.serial_in = 1'b1;
    bus.dvsr      = DW'(2);
    last_good     = 8'h00;
    #1;
    check("reset_data_out", 32'(bus.data_out), 32'h00);
    check("reset_byte_ready", 32'(bus.byte_ready), 32'h0);
    check("reset_state_idle", 32'(bus.state_dbg), 32'h0);
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    idle(64);

    // ---- table-driven frames ----
    for (int i = 0; i < 9; i++) begin
      set_dvsr(vecs[i].dvsr);
      if (vecs[i].exp_pulse) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].dvsr, vecs[i].stop_ticks);
      wait_drain($sformatf("vec%0d_drain", i), 64 * vecs[i].dvsr);
      @(negedge clk);
      check($sformatf("vec%0d_data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
      drive_bit(1'b1, vecs[i].gap_bits * 16 * vecs[i].dvsr);
    end
    last_good = 8'h69;

    // ---- glitch rejection: short low pulse in idle ----
    set_dvsr(2);
    drive_bit(1'b0, 4 * 2);
    drive_bit(1'b1, 16 * 2 * 2);
    @(negedge clk);
    check("glitch_state_idle", 32'(bus.state_dbg), 32'h0);
    check("glitch_data_held", 32'(bus.data_out), 32'(last_good));
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 2, 16);
    wait_drain("glitch_follow_drain", 128);
    last_good = 8'h3C;
    @(negedge clk);
    check("glitch_follow_data", 32'(bus.data_out), 32'(last_good));
    drive_bit(1'b1, 32);

    // ---- randomized frames against the byte-queue model ----
    for (int i = 0; i < 25; i++) begin
      int         dv;
      logic [7:0] d;
      bit         ok;
      int         gap;
      dv  = int'($urandom_range(1, 6));
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = int'($urandom_range(ok ? 0 : 1, 3));
      set_dvsr(dv);
      if (ok) begin
        exp_q.push_back(d);
        last_good = d;
      end
      send_frame(d, ok, dv, 16);
      wait_drain($sformatf("rand%0d_drain", i), 64 * dv);
      @(negedge clk);
      check($sformatf("rand%0d_data_out", i), 32'(bus.data_out), 32'(last_good));
      drive_bit(1'b1, gap * 16 * dv);
    end
    drive_bit(1'b1, 16 * 6);

    // ---- break condition, then async reset while the line is still low ----
    set_dvsr(2);
    exp_q.push_back(8'h5C);
    send_frame(8'h5C, 1'b1, 2, 16);
    wait_drain("pre_break_drain", 128);
    last_good = 8'h5C;
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 30 * 16 * 2);
    @(negedge clk);
    check("break_data_held", 32'(bus.data_out), 32'(last_good));
    #2 rst = 1'b1;
    #1;
    check("async_rst_data_out", 32'(bus.data_out), 32'h00);
    check("async_rst_byte_ready", 32'(bus.byte_ready), 32'h0);
    check("async_rst_state_idle", 32'(bus.state_dbg), 32'h0);
    bus.serial_in = 1'b1;
    idle(4);
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle(64);
    exp_q.push_back(8'hE7);
    send_frame(8'hE7, 1'b1, 2, 16);
    wait_drain("post_reset_drain", 128);
    @(negedge clk);
    check("post_reset_data_out", 32'(bus.data_out), 32'hE7);
    idle(64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_system.md
Name: uart_rx_system

Overview:
- Standalone UART receive subsystem: runtime-programmable baud tick generator, 2-flop input synchroniser and 16x-oversampling receive FSM.
- Frame format is 8N1 (1 start, 8 data LSB-first, 1 stop).
- Sits between an external serial RX pin and on-chip logic; presents each received byte with a one-cycle strobe.

Parameters:
- DVSR_WIDTH, 11, width of the dvsr divisor input.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16, not required to support other values.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  asynchronous serial line, idle high.
- dvsr  input  DVSR_WIDTH  baud divisor; one sample tick every dvsr clocks (0 treated as 1); held static during operation.
- data_out  output  8  last good received byte.
- byte_ready  output  1  one-clock pulse when data_out updates.

Behaviour:
- Reset values (async, rst=1):
  - data_out=0x00, byte_ready=0, FSM=IDLE.
  - tick counter=0, sample counter=0, bit counter=0, shift register=0.
  - Both synchroniser flops=1.
- Synchroniser: serial_in passes through 2 flops; rx_s is the output. All FSM decisions use rx_s, adding 2 clocks of latency.
- Tick generator:
  - Free-running counter 0..dvsr-1, wraps to 0.
  - tick=1 for one clock when the counter equals dvsr-1.
  - dvsr=1 (or 0) gives tick every clock.
  - dvsr change takes effect at the next wrap.
- FSM states IDLE, START, DATA, STOP; s = tick count within bit (0..15), n = data bit index (0..7).
  - IDLE: on rx_s==0, go to START with s=0. Ticks are ignored in IDLE.
  - START, on tick:
    - if s==7 and rx_s==1: glitch, return to IDLE.
    - if s==7 and rx_s==0: go to DATA with s=0, n=0.
    - otherwise s++.
  - DATA, on tick:
    - if s==15: shift rx_s in at MSB of shift register (shreg={rx_s,shreg[7:1]}), s=0.
    - if s==15 and n==7: go to STOP.
    - if s==15 and n<7: n++.
    - otherwise s++.
    - Each bit is therefore sampled at its midpoint.
  - STOP, on tick:
    - if s==15: latch rx_s as stop sample, return to IDLE.
    - if latched stop sample==1: data_out<=shreg and byte_ready=1 in the same clock.
    - if stop sample==0 (framing error): discard byte; data_out unchanged, no pulse.
    - otherwise s++.
- byte_ready is high exactly one clock per good frame and never high in other cycles.
- data_out holds its value until the next good frame.
- Back-to-back frames: a new start bit is accepted from the clock after returning to IDLE, so the stop bit may be as short as half a bit.
- Line held low continuously: after a framing error the FSM re-enters START immediately. A low break condition therefore produces no byte_ready.
- Reset mid-frame aborts immediately. Receiving resumes only on a fresh falling edge after reset release.
- Bit period = 16*dvsr clocks.

Test Plan:
- Reset: assert rst mid-frame -> data_out=0x00, byte_ready=0 immediately (async), with no clock edge required. Release rst; a subsequent full frame is received correctly.
- Basic receive, dvsr=2 (32 clocks/bit, 640 ns at 50 MHz): send start, bits 1,0,1,0,0,1,0,1 LSB-first, stop=1 -> byte_ready pulses once for 1 clock, data_out=0xA5 afterwards.
- Boundary bytes at dvsr=1: frames for 0x00 then 0xFF, back-to-back with a 1-bit stop -> two pulses; data_out=0x00, then 0xFF.
- Glitch rejection: drive serial_in low for 4*dvsr clocks in idle, then high -> no byte_ready, FSM back in IDLE. A following 0x3C frame is received as 0x3C.
- Framing error: send 0x5A with stop bit=0 -> no byte_ready, data_out keeps its previous value. The next good frame 0x81 is delivered.
- Divisor sweep: dvsr=5 and dvsr=27, send 0xC3 with a matching 16*dvsr bit period -> data_out=0xC3 with exactly one pulse per frame. Sample points lie within ±1 tick of mid-bit.
